// File: rtl/mul_seq_pkg.sv
// Shared types for the multiplier operand sequencer: FSM states, default width, operand pair.
package mul_seq_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD_A,
    LOAD_B,
    WAIT,
    HOLD
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } pair_t;

endpackage

// File: rtl/mul_seq_fifo.sv
// Synchronous FIFO of operand pairs with a registered occupancy count; head is read combinationally.
module mul_seq_fifo
  import mul_seq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pair_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage is pure data: no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds operand pairs into the repeated-addition multiplier and returns products on a stream.
// Optional watchdog in WAIT enabled by defining MUL_SEQ_TIMEOUT_EN.
module mul_operand_sequencer
  import mul_seq_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 70000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_data,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic             out_err,
  output logic             busy
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_w_t;

  state_t           state;
  state_t           state_nxt;
  pair_w_t          in_pair;
  pair_w_t          head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             head_zero;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             armed;
  logic             capture;
  logic             timeout;

  assign in_pair  = '{a: in_a, b: in_b};
  assign in_ready = !fifo_full;

  mul_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (pair_w_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .din   (in_pair),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_zero = (head.a == '0) || (head.b == '0);
  // a done seen before it has been low once in WAIT belongs to the previous operation
  assign capture   = (state == WAIT) && mul_done && armed;
  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             timer <= '0;
    else if (state != WAIT) timer <= '0;
    else                    timer <= timer + 1'b1;
  end

  assign timeout = (state == WAIT) && !capture && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          out_err <= 1'b0;
    else if (timeout)                    out_err <= 1'b1;
    else if (state == HOLD && out_ready) out_err <= 1'b0;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout            = 1'b0;
  assign out_err            = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    mul_start = 1'b0;
    mul_data  = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = head_zero ? HOLD : START;
        end
      end
      START: begin
        mul_start = 1'b1;
        state_nxt = LOAD_A;
      end
      LOAD_A: begin
        mul_data  = a_reg;
        state_nxt = LOAD_B;
      end
      LOAD_B: begin
        mul_data  = b_reg;
        state_nxt = WAIT;
      end
      WAIT: begin
        mul_data = b_reg;
        if (capture || timeout) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      a_reg <= head.a;
      b_reg <= head.b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      out_product <= '0;
    end else begin
      if (state == START)                armed <= 1'b0;
      else if (state == WAIT && !mul_done) armed <= 1'b1;

      if (pop && head_zero) out_product <= '0;
      else if (capture)     out_product <= mul_result;
      else if (timeout)     out_product <= '0;
    end
  end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Directed bench for mul_operand_sequencer with a behavioural multiplier controller model.
module tb_mul_operand_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         mul_start;
  logic [W-1:0] mul_data;
  logic         mul_done = 1'b1;
  logic [W-1:0] mul_result = 16'h5a5a;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_product;
  logic         out_err;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_operand_sequencer #(
    .WIDTH          (W),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_start   (mul_start),
    .mul_data    (mul_data),
    .mul_done    (mul_done),
    .mul_result  (mul_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_err     (out_err),
    .busy        (busy)
  );

  // Controller/datapath model: loads A then B after start, drops done after clr_dly, raises it after done_dly.
  int           clr_dly  = 0;
  int           done_dly = 3;
  bit           hang     = 1'b0;
  int           ph       = 0;
  int           cnt      = 0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = '0;
  int           start_cnt = 0;

  always @(posedge clk) begin
    if (mul_start) start_cnt <= start_cnt + 1;
    if (mul_start) begin
      ph  <= 1;
      cnt <= 0;
    end else if (ph == 1) begin
      ma <= mul_data;
      ph <= 2;
    end else if (ph == 2) begin
      mb  <= mul_data;
      ph  <= 3;
      cnt <= 0;
    end else if (ph == 3) begin
      cnt <= cnt + 1;
      if (cnt == clr_dly) mul_done <= 1'b0;
      if (cnt == done_dly && !hang) begin
        mul_done   <= 1'b1;
        mul_result <= ma * mb;
        ph         <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("push_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid) return;
    end
    cyc = -1;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           starts;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    int s0;
    logic [W-1:0] exp_q [5];

    vecs[0] = '{a: 16'd0,     b: 16'd9,   exp: 16'd0,     starts: 0};
    vecs[1] = '{a: 16'd9,     b: 16'd0,   exp: 16'd0,     starts: 0};
    vecs[2] = '{a: 16'd7,     b: 16'd7,   exp: 16'd49,    starts: 1};
    vecs[3] = '{a: 16'd300,   b: 16'd300, exp: 16'd24464, starts: 1};
    vecs[4] = '{a: 16'd65535, b: 16'd2,   exp: 16'd65534, starts: 1};
    vecs[5] = '{a: 16'd1,     b: 16'd1,   exp: 16'd1,     starts: 1};
    exp_q   = '{16'd6, 16'd12, 16'd20, 16'd30, 16'd42};

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_data", mul_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_out_err", out_err, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // (17,5): cycle-accurate serialisation
    push(16'd17, 16'd5);
    s0 = start_cnt;
    @(negedge clk);
    check("t1_pop_start", mul_start, 0);
    check("t1_pop_busy", busy, 0);
    @(negedge clk);
    check("t1_start", mul_start, 1);
    check("t1_start_busy", busy, 1);
    @(negedge clk);
    check("t1_lda_start", mul_start, 0);
    check("t1_lda_data", mul_data, 17);
    @(negedge clk);
    check("t1_ldb_data", mul_data, 5);
    @(negedge clk);
    check("t1_wait_data", mul_data, 5);
    wait_out(cyc);
    check("t1_valid", out_valid, 1);
    check("t1_product", out_product, 85);
    check("t1_err", out_err, 0);
    check("t1_start_pulses", start_cnt - s0, 1);
    handshake();
    check("t1_valid_cleared", out_valid, 0);

    // Table: zero bypass, wrap-around, ordinary products
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].a, vecs[i].b);
      s0 = start_cnt;
      wait_out(cyc);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_product", i), out_product, vecs[i].exp);
      check($sformatf("vec%0d_err", i), out_err, 0);
      check($sformatf("vec%0d_starts", i), start_cnt - s0, vecs[i].starts);
      if (vecs[i].starts == 0) check($sformatf("vec%0d_latency", i), cyc, 2);
      handshake();
    end

    // Stale done held high from the previous operation
    clr_dly  = 6;
    done_dly = 9;
    push(16'd11, 16'd13);
    wait_out(cyc);
    check("stale_latency", cyc, 16);
    check("stale_product", out_product, 143);
    handshake();
    clr_dly  = 0;
    done_dly = 3;

    // Backlog with downstream stalled, then drain in order
    for (int i = 0; i < 5; i++) push(16'(i + 2), 16'(i + 3));
    @(negedge clk);
    check("backlog_in_ready_full", in_ready, 0);
    repeat (3) @(negedge clk);
    check("backlog_still_full", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_out(cyc);
      check($sformatf("drain%0d_valid", i), out_valid, 1);
      check($sformatf("drain%0d_product", i), out_product, exp_q[i]);
      @(posedge clk);
    end
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("drain_in_ready", in_ready, 1);

    // Asynchronous reset during WAIT, with a pair still buffered
    hang = 1'b1;
    push(16'd8, 16'd8);
    push(16'd3, 16'd3);
    repeat (6) @(negedge clk);
    check("mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mul_data", mul_data, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hang  = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_fifo_empty_busy", busy, 0);
    push(16'd9, 16'd10);
    wait_out(cyc);
    check("mid_after_product", out_product, 90);
    handshake();

`ifdef MUL_SEQ_TIMEOUT_EN
    // Watchdog: done never arrives
    hang = 1'b1;
    push(16'd4, 16'd4);
    wait_out(cyc);
    check("to_latency", cyc, 25);
    check("to_err", out_err, 1);
    check("to_product", out_product, 0);
    handshake();
    check("to_err_cleared", out_err, 0);
    hang = 1'b0;
    push(16'd3, 16'd3);
    wait_out(cyc);
    check("to_next_product", out_product, 9);
    check("to_next_err", out_err, 0);
    handshake();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mul_operand_sequencer.md
Name: mul_operand_sequencer

Overview:
- Upstream feeder for the repeated-addition multiplier (MUL_datapath + controller pair).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Serialises each pair onto the multiplier's shared data_in bus with the start/LdA/LdB cycle timing, waits for done, then presents the product on a valid/ready result stream.

Parameters:
- WIDTH, 16, operand/product width; matches the datapath bus.
- FIFO_DEPTH, 4, operand-pair buffer entries; power of two, >= 2.
- TIMEOUT_CYCLES, 70000, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock, shared with the multiplier.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals not-full.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier (repeat count).
- mul_start  out  1  start pulse to the controller.
- mul_data  out  WIDTH  drives datapath data_in.
- mul_done  in  1  controller done (level).
- mul_result  in  WIDTH  datapath Result.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts.
- out_product  out  WIDTH  product, low WIDTH bits.
- out_err  out  1  timeout flag; tied 0 without the macro.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, FIFO empty, in_ready=1, mul_start=0, mul_data=0, out_valid=0, out_product=0, out_err=0, busy=0, armed=0.
- The multiplier has no reset. After a mid-operation reset the sequencer restarts cleanly; the multiplier recovers only on the next mul_start.
- FIFO push on in_valid&&in_ready. A push when full is impossible because in_ready=0.
- Simultaneous push and pop is allowed at any occupancy except full. At full, in_ready=0 that cycle and no bypass is provided.
- Popped data is available to the FSM the cycle after the push, at the earliest.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, HOLD.
  - IDLE: FIFO non-empty -> pop the head.
    - If a==0 or b==0 (zero bypass): out_product=0, out_valid=1, go to HOLD. mul_start is never asserted.
    - Otherwise: go to START.
  - START: mul_start=1 for exactly one cycle; armed cleared.
  - LOAD_A: mul_data=a for one cycle; mul_start=0.
  - LOAD_B: mul_data=b for one cycle.
  - WAIT: mul_data holds b.
    - mul_done=0 sampled -> armed=1.
    - mul_done=1 && armed -> capture mul_result into out_product, out_valid=1, go to HOLD.
    - mul_done=1 && !armed is a stale done from the previous operation and is ignored.
  - HOLD: out_valid held with stable out_product until out_ready; on handshake out_valid=0 and go to IDLE. The next pop happens at the earliest in IDLE the following cycle.
- Latency for a non-zero pair at the FIFO head in IDLE: mul_start asserted 1 cycle after the pop, A 2 cycles after, B 3 cycles after. Product appears 1 cycle after the armed done is sampled.
- Arithmetic: no carry or overflow detection; the product wraps mod 2^WIDTH, matching the datapath.
- FIFO pointers wrap mod FIFO_DEPTH. The count is a separate (log2(FIFO_DEPTH)+1)-bit register.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: MUL_SEQ_TIMEOUT_EN.
- With the macro:
  - A cycle counter runs in WAIT.
  - Reaching TIMEOUT_CYCLES without an armed done: out_product=0, out_err=1, out_valid=1, go to HOLD.
  - out_err clears on the out handshake.
- Without the macro: no counter; out_err is constant 0; WAIT waits indefinitely.

Decomposition:
- Package mul_seq_pkg holds:
  - state enum (IDLE..HOLD);
  - default WIDTH constant;
  - operand-pair struct {a, b}.
- One sub-module: mul_seq_fifo, a synchronous FIFO of pair structs with push/pop/full/empty and the same async active-low reset.

Test Plan:
- Push (17,5) with a behavioural controller model -> mul_start pulses 1 cycle, then mul_data=17, then 5 on consecutive cycles; done later -> out_product=85, out_err=0.
- Push (0,9) and (9,0) -> out_product=0 each; mul_start never asserted; out_valid 1 cycle after the pop.
- Push 5 pairs back-to-back with out_ready=0 -> in_ready falls after the 4th accept is buffered. Releasing out_ready drains all pairs in order; products are 6,12,20,30,42 for (2,3),(3,4),(4,5),(5,6),(6,7).
- Hold mul_done=1 continuously from the previous operation into the next START -> no capture until done is seen low, then high; product correct.
- Assert rst_n=0 during WAIT -> all outputs reset immediately (async); the FIFO is empty afterwards; a new pair completes normally.
- With MUL_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20, never assert done -> out_valid=1, out_err=1, out_product=0 after 20 WAIT cycles; the next pair proceeds normally.
